// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder.
// A request is accepted in IDLE and held for WAIT_CYCLES wait states.
// The memory access then happens once, on entry to RESP, and the result is
// held until the initiator takes it. Memory is flop-based so reset can clear it.

module dmem_responder #(
  parameter int DATA_WIDTH      = 64,
  parameter int WORD_ADDR_WIDTH = 8,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [WORD_ADDR_WIDTH+2:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  input  logic [DATA_WIDTH/8-1:0]      req_be,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH = WORD_ADDR_WIDTH + 3;
  localparam int DEPTH      = 2 ** WORD_ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                      state;
  logic [3:0]                  wait_cnt;

  logic                        cap_we;
  logic [ADDR_WIDTH-1:0]       cap_addr;
  logic [DATA_WIDTH-1:0]       cap_wdata;
  logic [BE_WIDTH-1:0]         cap_be;

  logic [DATA_WIDTH-1:0]       mem [DEPTH];

  logic                        accept;
  logic                        do_access;
  logic                        acc_we;
  logic [ADDR_WIDTH-1:0]       acc_addr;
  logic [DATA_WIDTH-1:0]       acc_wdata;
  logic [BE_WIDTH-1:0]         acc_be;
  logic [WORD_ADDR_WIDTH-1:0]  acc_idx;
  logic                        acc_misaligned;
  logic [DATA_WIDTH-1:0]       rd_word;
  logic [DATA_WIDTH-1:0]       wr_word;
  logic [DATA_WIDTH-1:0]       result_data;

  // With zero wait states the access happens on the accept edge itself, so the
  // access operands come straight from the request bus in IDLE and from the
  // captured copy otherwise.
  always_comb begin
    accept         = req_valid && req_ready;
    acc_we         = (state == ST_IDLE) ? req_we    : cap_we;
    acc_addr       = (state == ST_IDLE) ? req_addr  : cap_addr;
    acc_wdata      = (state == ST_IDLE) ? req_wdata : cap_wdata;
    acc_be         = (state == ST_IDLE) ? req_be    : cap_be;
    acc_idx        = acc_addr[ADDR_WIDTH-1:3];
    acc_misaligned = (acc_addr[2:0] != 3'd0);
    do_access      = ((state == ST_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd1));
  end

  // Read the addressed word and merge the enabled store bytes into it.
  always_comb begin
    rd_word = mem[acc_idx];
    wr_word = rd_word;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (acc_be[b]) begin
        wr_word[b*8 +: 8] = acc_wdata[b*8 +: 8];
      end
    end
    result_data = '0;
    if (!acc_misaligned && !acc_we) begin
      result_data = rd_word;
    end
  end

  // Memory array: cleared by reset, written only by an aligned store at access time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_access && acc_we && !acc_misaligned) begin
      mem[acc_idx] <= wr_word;
    end
  end

  // Request/response FSM with registered handshake outputs and response data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              wait_cnt  <= 4'd0;
              rsp_valid <= 1'b1;
              rsp_rdata <= result_data;
              rsp_err   <= acc_misaligned;
            end else begin
              state     <= ST_WAIT;
              wait_cnt  <= WAIT_LOAD;
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state     <= ST_RESP;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= result_data;
            rsp_err   <= acc_misaligned;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          wait_cnt  <= 4'd0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Two instances share the request bus: "main" uses two wait states and a
// controllable rsp_ready, "zero" uses no wait states with rsp_ready tied high.
// The reference model is a plain word array updated in accept order.

module tb_dmem_responder;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          accept_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [10:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        sel;
  logic        rsp_ready;
  int          ready_mode;

  logic        main_req_ready, main_rsp_valid, main_rsp_err;
  logic [63:0] main_rsp_rdata;
  logic        zero_req_ready, zero_rsp_valid, zero_rsp_err;
  logic [63:0] zero_rsp_rdata;

  exp_t        exp_q_main[$];
  exp_t        exp_q_zero[$];
  logic [63:0] model_main [256];
  logic [63:0] model_zero [256];
  bit          seen_main;
  bit          seen_zero;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  dmem_responder #(.DATA_WIDTH(64), .WORD_ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(main_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(main_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(main_rsp_rdata), .rsp_err(main_rsp_err)
  );

  dmem_responder #(.DATA_WIDTH(64), .WORD_ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_zero (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(zero_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(zero_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(zero_rsp_rdata), .rsp_err(zero_rsp_err)
  );

  // Free-running clock and cycle counter used for latency bookkeeping.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Response acceptance for the main instance: always, randomly, or held off.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Compare one instance's outputs against the head of its expectation queue.
  task automatic monitorInst(input string tag, input bit inst, input logic rdy, input logic vld,
                             input logic [63:0] rdata, input logic err, input logic take, input int lat);
    int   qs;
    exp_t e;
    bit   seen;
    qs = inst ? exp_q_zero.size() : exp_q_main.size();
    checkOutput({tag, "_req_ready"}, 64'(rdy), 64'(qs == 0));
    if (vld) begin
      if (qs == 0) begin
        checkOutput({tag, "_unexpected_rsp"}, 64'(vld), 64'(0));
      end else begin
        e    = inst ? exp_q_zero[0] : exp_q_main[0];
        seen = inst ? seen_zero : seen_main;
        if (!seen) begin
          checkOutput({tag, "_latency"}, 64'(cyc - e.accept_cyc), 64'(lat + 1));
        end
        checkOutput({tag, "_rdata"}, rdata, e.rdata);
        checkOutput({tag, "_err"}, 64'(err), 64'(e.err));
        if (inst) seen_zero = 1'b1; else seen_main = 1'b1;
        if (take) begin
          if (inst) begin
            void'(exp_q_zero.pop_front());
            seen_zero = 1'b0;
          end else begin
            void'(exp_q_main.pop_front());
            seen_main = 1'b0;
          end
        end
      end
    end
  endtask

  // Monitor samples 1 time unit after the falling edge, once inputs have settled.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      monitorInst("main", 1'b0, main_req_ready, main_rsp_valid, main_rsp_rdata, main_rsp_err, rsp_ready, 2);
      monitorInst("zero", 1'b1, zero_req_ready, zero_rsp_valid, zero_rsp_rdata, zero_rsp_err, 1'b1, 0);
    end else begin
      seen_main = 1'b0;
      seen_zero = 1'b0;
    end
  end

  // Present one request, wait for acceptance, then push its expected response.
  task automatic applyStimulus(input bit inst, input logic we, input logic [10:0] addr,
                               input logic [63:0] wdata, input logic [7:0] be, output int acc_cyc);
    int          waited;
    int          idx;
    exp_t        e;
    logic [63:0] word;
    sel       = inst;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    waited    = 0;
    acc_cyc   = 0;
    while (!(inst ? zero_req_ready : main_req_ready)) begin
      if (waited == 200) begin
        timeoutFail("accept_wait");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    acc_cyc      = cyc;
    e.accept_cyc = acc_cyc;
    idx          = int'(addr[10:3]);
    word         = inst ? model_zero[idx] : model_main[idx];
    if (addr[2:0] != 3'd0) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (inst) model_zero[idx] = word; else model_main[idx] = word;
      e.rdata = '0;
      e.err   = 1'b0;
    end else begin
      e.rdata = word;
      e.err   = 1'b0;
    end
    @(posedge clk);
    if (inst) exp_q_zero.push_back(e); else exp_q_main.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic randomReq(input bit inst);
    logic [10:0] a;
    int          acc;
    a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 255)) << 3
                                    : 11'($urandom_range(0, 15)) << 3;
    if ($urandom_range(0, 4) == 0) a[2:0] = 3'($urandom_range(1, 7));
    applyStimulus(inst, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), acc);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (exp_q_main.size() != 0 || exp_q_zero.size() != 0) begin
      if (n == 300) begin
        timeoutFail("response_wait");
        exp_q_main.delete();
        exp_q_zero.delete();
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Assert reset at a falling edge, check outputs right away, release two cycles later.
  task automatic applyReset();
    rst = 1'b0;
    #1;
    checkOutput("rst_req_ready", 64'(main_req_ready), 64'(1));
    checkOutput("rst_rsp_valid", 64'(main_rsp_valid), 64'(0));
    checkOutput("rst_rsp_rdata", main_rsp_rdata, 64'(0));
    checkOutput("rst_rsp_err", 64'(main_rsp_err), 64'(0));
    checkOutput("rst_zero_req_ready", 64'(zero_req_ready), 64'(1));
    checkOutput("rst_zero_rsp_valid", 64'(zero_rsp_valid), 64'(0));
    exp_q_main.delete();
    exp_q_zero.delete();
    for (int i = 0; i < 256; i++) begin
      model_main[i] = '0;
      model_zero[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int acc;
    int prev;
    int n;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    sel        = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    applyReset();

    // Load of a cleared word, then a partial store and its readback.
    applyStimulus(1'b0, 1'b0, 11'h010, 64'h0, 8'h00, acc);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 11'h018, 64'h1122334455667788, 8'h0F, acc);
    applyStimulus(1'b0, 1'b0, 11'h018, 64'h0, 8'h00, acc);
    waitIdle();
    checkOutput("model_partial_store", model_main[3], 64'h0000000055667788);

    // Misaligned load, then the word it would have hit is unchanged.
    applyStimulus(1'b0, 1'b0, 11'h01C, 64'h0, 8'h00, acc);
    applyStimulus(1'b0, 1'b1, 11'h01B, 64'hFFFFFFFFFFFFFFFF, 8'hFF, acc);
    applyStimulus(1'b0, 1'b0, 11'h018, 64'h0, 8'h00, acc);
    applyStimulus(1'b0, 1'b1, 11'h028, 64'hDEADBEEFDEADBEEF, 8'h00, acc);
    applyStimulus(1'b0, 1'b0, 11'h028, 64'h0, 8'h00, acc);
    waitIdle();

    // Hold the response for five cycles while the request bus churns.
    ready_mode = 2;
    applyStimulus(1'b0, 1'b0, 11'h018, 64'h0, 8'h00, acc);
    n = 0;
    while (!main_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) timeoutFail("hold_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      sel       = 1'b0;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 11'($urandom);
      req_wdata = {$urandom, $urandom};
      req_be    = 8'($urandom);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    ready_mode = 0;
    waitIdle();

    // Random traffic with random response back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 60; i++) randomReq(1'b0);
    waitIdle();

    // Reset while a store is waiting: the store must never land.
    applyStimulus(1'b0, 1'b1, 11'h020, 64'hA5A5A5A5A5A5A5A5, 8'hFF, acc);
    applyReset();
    applyStimulus(1'b0, 1'b0, 11'h020, 64'h0, 8'h00, acc);
    for (int i = 0; i < 40; i++) randomReq(1'b0);
    waitIdle();
    ready_mode = 0;

    // Zero wait states: back-to-back store/load pairs, one accept every two cycles.
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, (i % 2) == 0, 11'((i / 2) % 3) << 3, {$urandom, $urandom}, 8'($urandom), acc);
      if (i > 0) checkOutput("zero_accept_gap", 64'(acc - prev), 64'(2));
      prev = acc;
    end
    applyStimulus(1'b1, 1'b0, 11'h00D, 64'h0, 8'h00, acc);
    waitIdle();
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
